// File: rtl/noc_pkg.sv
// Shared types for the epidemic-routing mesh.
// Direction encoding, flit type and key field widths.
package noc_pkg;

    typedef logic [7:0] flit_t;

    typedef enum logic [2:0] {
        DIR_L   = 3'd0,
        DIR_R   = 3'd1,
        DIR_T   = 3'd2,
        DIR_B   = 3'd3,
        DIR_INJ = 3'd4
    } dir_e;

    localparam int NUM_DIRS = 4;
    localparam int NUM_SRCS = 5;
    localparam int SRC_W    = 4;
    localparam int SEQ_W    = 4;

    // Side a packet must not be echoed back to; injected packets exclude none.
    function automatic logic [NUM_DIRS-1:0] arrival_mask(input logic [2:0] s);
        logic [NUM_DIRS-1:0] m;
        unique case (s)
            DIR_L:   m = 4'b0001;
            DIR_R:   m = 4'b0010;
            DIR_T:   m = 4'b0100;
            DIR_B:   m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/epidemic_seen_cache.sv
// Recently-seen packet cache: fully associative lookup,
// FIFO replacement through a wrapping write pointer.
module epidemic_seen_cache
    import noc_pkg::*;
#(
    parameter int CACHE_DEPTH = 8
) (
    input  logic  clk,
    input  logic  rstn,
    input  flit_t i_key,
    input  logic  i_wr_en,
    output logic  o_hit
);

    localparam int PTR_W = $clog2(CACHE_DEPTH);

    flit_t                  r_key [CACHE_DEPTH];
    logic [CACHE_DEPTH-1:0] r_vld;
    logic [PTR_W-1:0]       r_wptr;

    // Compare the key against every valid entry in parallel.
    always_comb begin
        o_hit = 1'b0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            if (r_vld[i] && (r_key[i] == i_key)) begin
                o_hit = 1'b1;
            end
        end
    end

    // Insert at the write pointer; oldest entry is overwritten on wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_vld  <= '0;
            r_wptr <= '0;
            for (int i = 0; i < CACHE_DEPTH; i++) begin
                r_key[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_key[r_wptr] <= i_key;
            r_vld[r_wptr] <= 1'b1;
            r_wptr        <= r_wptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/epidemic_node.sv
// One tile of the epidemic-routing mesh: flood new packets, drop repeats.
// Optional counters enabled with EPIDEMIC_NODE_STATS_EN.
module epidemic_node
    import noc_pkg::*;
#(
    parameter logic [3:0] NODE_ID     = 4'd0,
    parameter logic [3:0] EDGE_MASK   = 4'b1111,
    parameter int         CACHE_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_valid_l,
    input  logic       i_valid_r,
    input  logic       i_valid_t,
    input  logic       i_valid_b,
    input  logic [7:0] i_data_l,
    input  logic [7:0] i_data_r,
    input  logic [7:0] i_data_t,
    input  logic [7:0] i_data_b,
    output logic       o_ready_l,
    output logic       o_ready_r,
    output logic       o_ready_t,
    output logic       o_ready_b,
    output logic       o_valid_l,
    output logic       o_valid_r,
    output logic       o_valid_t,
    output logic       o_valid_b,
    output logic [7:0] o_data_l,
    output logic [7:0] o_data_r,
    output logic [7:0] o_data_t,
    output logic [7:0] o_data_b,
    input  logic       i_ready_l,
    input  logic       i_ready_r,
    input  logic       i_ready_t,
    input  logic       i_ready_b,
    input  logic       inj_valid,
    input  logic [7:0] inj_data,
    output logic       inj_ready,
    output logic       dlv_valid,
    output logic [7:0] dlv_data
`ifdef EPIDEMIC_NODE_STATS_EN
    ,
    output logic [15:0] stat_fwd,
    output logic [15:0] stat_drop
`endif
);

    logic [NUM_DIRS-1:0] w_in_valid;
    logic [NUM_DIRS-1:0] w_nb_ready;
    logic [NUM_DIRS-1:0] w_o_ready;
    logic [NUM_SRCS-1:0] w_load;
    flit_t               w_in_data [NUM_SRCS];

    logic [NUM_SRCS-1:0] r_full;
    flit_t               r_sdata [NUM_SRCS];
    logic [2:0]          r_rr;
    logic [NUM_DIRS-1:0] r_pend;
    flit_t               r_odata;
    logic                r_dlv_valid;
    flit_t               r_dlv_data;

    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_rr_nxt;
    logic       w_arb;
    logic       w_hit;
    logic       w_miss;
    flit_t      w_key;

    assign w_in_valid = {i_valid_b, i_valid_t, i_valid_r, i_valid_l};
    assign w_nb_ready = {i_ready_b, i_ready_t, i_ready_r, i_ready_l};

    assign w_in_data[0] = i_data_l;
    assign w_in_data[1] = i_data_r;
    assign w_in_data[2] = i_data_t;
    assign w_in_data[3] = i_data_b;
    assign w_in_data[4] = inj_data;

    assign w_o_ready = ~r_full[NUM_DIRS-1:0] & EDGE_MASK;
    assign inj_ready = ~r_full[DIR_INJ];
    assign w_load    = {inj_valid & ~r_full[DIR_INJ], w_in_valid & w_o_ready};

    assign o_ready_l = w_o_ready[0];
    assign o_ready_r = w_o_ready[1];
    assign o_ready_t = w_o_ready[2];
    assign o_ready_b = w_o_ready[3];

    // Round-robin pick of the first full slot at or after the RR pointer.
    always_comb begin : p_arb
        int idx;
        w_found = 1'b0;
        w_win   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_SRCS; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NUM_SRCS) begin
                idx = idx - NUM_SRCS;
            end
            if (!w_found && r_full[idx]) begin
                w_found = 1'b1;
                w_win   = 3'(idx);
            end
        end
    end

    assign w_rr_nxt = (w_win == DIR_INJ) ? 3'd0 : w_win + 3'd1;
    assign w_arb    = w_found && (r_pend == '0);
    assign w_key    = r_sdata[w_win];
    assign w_miss   = w_arb && !w_hit;

    epidemic_seen_cache #(
        .CACHE_DEPTH(CACHE_DEPTH)
    ) u_cache (
        .clk    (clk),
        .rstn   (rstn),
        .i_key  (w_key),
        .i_wr_en(w_miss),
        .o_hit  (w_hit)
    );

    // Input slots: load on handshake, free when they win arbitration.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_full <= '0;
            for (int i = 0; i < NUM_SRCS; i++) begin
                r_sdata[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRCS; i++) begin
                if (w_load[i]) begin
                    r_full[i]  <= 1'b1;
                    r_sdata[i] <= w_in_data[i];
                end else if (w_arb && (w_win == 3'(i))) begin
                    r_full[i] <= 1'b0;
                end
            end
        end
    end

    // Advance the RR pointer past each winner.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr <= '0;
        end else if (w_arb) begin
            r_rr <= w_rr_nxt;
        end
    end

    // Broadcast stage: load on miss, retire each side on its handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pend  <= '0;
            r_odata <= '0;
        end else if (w_miss) begin
            r_pend  <= EDGE_MASK & ~arrival_mask(w_win);
            r_odata <= w_key;
        end else begin
            r_pend <= r_pend & ~w_nb_ready;
        end
    end

    // Local delivery pulse for new packets that came in over a link.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dlv_valid <= 1'b0;
            r_dlv_data  <= '0;
        end else begin
            r_dlv_valid <= w_miss && (w_win != DIR_INJ);
            if (w_miss && (w_win != DIR_INJ)) begin
                r_dlv_data <= w_key;
            end
        end
    end

    assign o_valid_l = r_pend[0];
    assign o_valid_r = r_pend[1];
    assign o_valid_t = r_pend[2];
    assign o_valid_b = r_pend[3];
    assign o_data_l  = r_odata;
    assign o_data_r  = r_odata;
    assign o_data_t  = r_odata;
    assign o_data_b  = r_odata;
    assign dlv_valid = r_dlv_valid;
    assign dlv_data  = r_dlv_data;

`ifdef EPIDEMIC_NODE_STATS_EN
    logic [15:0] r_stat_fwd;
    logic [15:0] r_stat_drop;

    // Saturating miss/hit counters.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_fwd  <= '0;
            r_stat_drop <= '0;
        end else if (w_arb) begin
            if (!w_hit && (r_stat_fwd != 16'hFFFF)) begin
                r_stat_fwd <= r_stat_fwd + 16'd1;
            end
            if (w_hit && (r_stat_drop != 16'hFFFF)) begin
                r_stat_drop <= r_stat_drop + 16'd1;
            end
        end
    end

    assign stat_fwd  = r_stat_fwd;
    assign stat_drop = r_stat_drop;
`endif

endmodule

// File: tb/tb_epidemic_node.sv
// Self-checking bench for epidemic_node: vector table plus scoreboard.
// Build with EPIDEMIC_NODE_STATS_EN to also check the counters.
`timescale 1ns/1ps
module tb_epidemic_node;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn;
    logic       rstn_c;

    logic [4:0] in_v;
    logic [7:0] in_d [5];
    logic [3:0] ir;
    logic [3:0] ordy;
    logic [3:0] ov;
    logic [7:0] od_l, od_r, od_t, od_b;
    logic       inj_rdy;
    logic       dv;
    logic [7:0] dd;

    logic [4:0] in_vc;
    logic [7:0] in_dc [5];
    logic [3:0] irc;
    logic [3:0] ordy_c;
    logic [3:0] ov_c;
    logic [7:0] odc_l, odc_r, odc_t, odc_b;
    logic       inj_rdy_c;
    logic       dv_c;
    logic [7:0] dd_c;

`ifdef EPIDEMIC_NODE_STATS_EN
    logic [15:0] stat_fwd, stat_drop, stat_fwd_c, stat_drop_c;
`endif

    epidemic_node #(
        .NODE_ID(4'd5), .EDGE_MASK(4'b1111), .CACHE_DEPTH(8)
    ) dut (
        .clk(clk), .rstn(rstn),
        .i_valid_l(in_v[0]), .i_valid_r(in_v[1]),
        .i_valid_t(in_v[2]), .i_valid_b(in_v[3]),
        .i_data_l(in_d[0]), .i_data_r(in_d[1]),
        .i_data_t(in_d[2]), .i_data_b(in_d[3]),
        .o_ready_l(ordy[0]), .o_ready_r(ordy[1]),
        .o_ready_t(ordy[2]), .o_ready_b(ordy[3]),
        .o_valid_l(ov[0]), .o_valid_r(ov[1]),
        .o_valid_t(ov[2]), .o_valid_b(ov[3]),
        .o_data_l(od_l), .o_data_r(od_r),
        .o_data_t(od_t), .o_data_b(od_b),
        .i_ready_l(ir[0]), .i_ready_r(ir[1]),
        .i_ready_t(ir[2]), .i_ready_b(ir[3]),
        .inj_valid(in_v[4]), .inj_data(in_d[4]), .inj_ready(inj_rdy),
        .dlv_valid(dv), .dlv_data(dd)
`ifdef EPIDEMIC_NODE_STATS_EN
        , .stat_fwd(stat_fwd), .stat_drop(stat_drop)
`endif
    );

    epidemic_node #(
        .NODE_ID(4'd0), .EDGE_MASK(4'b0110), .CACHE_DEPTH(8)
    ) dut_c (
        .clk(clk), .rstn(rstn_c),
        .i_valid_l(in_vc[0]), .i_valid_r(in_vc[1]),
        .i_valid_t(in_vc[2]), .i_valid_b(in_vc[3]),
        .i_data_l(in_dc[0]), .i_data_r(in_dc[1]),
        .i_data_t(in_dc[2]), .i_data_b(in_dc[3]),
        .o_ready_l(ordy_c[0]), .o_ready_r(ordy_c[1]),
        .o_ready_t(ordy_c[2]), .o_ready_b(ordy_c[3]),
        .o_valid_l(ov_c[0]), .o_valid_r(ov_c[1]),
        .o_valid_t(ov_c[2]), .o_valid_b(ov_c[3]),
        .o_data_l(odc_l), .o_data_r(odc_r),
        .o_data_t(odc_t), .o_data_b(odc_b),
        .i_ready_l(irc[0]), .i_ready_r(irc[1]),
        .i_ready_t(irc[2]), .i_ready_b(irc[3]),
        .inj_valid(in_vc[4]), .inj_data(in_dc[4]), .inj_ready(inj_rdy_c),
        .dlv_valid(dv_c), .dlv_data(dd_c)
`ifdef EPIDEMIC_NODE_STATS_EN
        , .stat_fwd(stat_fwd_c), .stat_drop(stat_drop_c)
`endif
    );

    typedef struct {
        logic [7:0] data;
        logic [3:0] mask;
    } bc_t;

    typedef struct {
        int         side;
        logic [7:0] data;
        logic       drop;
        logic [3:0] mask;
    } vec_t;

    bc_t        q_bc [$];
    logic [7:0] q_dlv [$];
    vec_t       tbl [$];

    int total = 0;
    int bad   = 0;
    int n_fwd = 0;
    int n_drop = 0;

    logic [3:0] prev_ov = 4'h0;
    bc_t        m_eb;
    logic [7:0] m_ed;
    logic       c_dlv_seen = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(int s);
        return (s == 4) ? inj_rdy : ordy[s];
    endfunction

    // Scoreboard: pop an expectation for every delivery and new broadcast.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_ov = 4'h0;
        end else begin
            if (dv) begin
                total++;
                if (q_dlv.size() == 0) begin
                    bad++;
                    $display("FAIL dlv_unexpected got=%h", dd);
                end else begin
                    m_ed = q_dlv.pop_front();
                    if (dd !== m_ed) begin
                        bad++;
                        $display("FAIL dlv_data got=%h want=%h", dd, m_ed);
                    end
                end
            end
            if ((ov != 4'h0) && (prev_ov == 4'h0)) begin
                total++;
                if (q_bc.size() == 0) begin
                    bad++;
                    $display("FAIL bc_unexpected mask=%b data=%h", ov, od_l);
                end else begin
                    m_eb = q_bc.pop_front();
                    if (ov !== m_eb.mask || od_l !== m_eb.data ||
                        od_r !== m_eb.data || od_t !== m_eb.data ||
                        od_b !== m_eb.data) begin
                        bad++;
                        $display("FAIL bc got=%b/%h,%h,%h,%h want=%b/%h",
                                 ov, od_l, od_r, od_t, od_b,
                                 m_eb.mask, m_eb.data);
                    end
                end
            end
            prev_ov = ov;
        end
        if (rstn_c && dv_c) c_dlv_seen = 1'b1;
    end

    task automatic send(int s, logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk);
        in_v[s] = 1'b1;
        in_d[s] = d;
        while (!rdy(s) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout side=%0d", s);
        end
        @(posedge clk);
        #1;
        in_v[s] = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rstn   = 1'b0;
        rstn_c = 1'b0;
        in_v   = '0;
        in_vc  = '0;
        ir     = 4'hF;
        irc    = 4'h0;
        for (int i = 0; i < 5; i++) begin
            in_d[i]  = '0;
            in_dc[i] = '0;
        end

        #2;
        chk("rst_ov", 32'(ov), 32'h0);
        chk("rst_ordy", 32'(ordy), 32'hF);
        chk("rst_inj_rdy", 32'(inj_rdy), 32'h1);
        chk("rst_dlv", 32'({dv, dd}), 32'h0);
        chk("rst_odata", 32'({od_l, od_r, od_t, od_b}), 32'h0);
        chk("rst_ordy_c", 32'(ordy_c), 32'h6);
        @(negedge clk);
        rstn   = 1'b1;
        rstn_c = 1'b1;

        tbl.push_back('{0, 8'h35, 1'b0, 4'b1110});
        tbl.push_back('{2, 8'h35, 1'b1, 4'b0000});
        tbl.push_back('{4, 8'h50, 1'b0, 4'b1111});
        tbl.push_back('{4, 8'h50, 1'b1, 4'b0000});
        tbl.push_back('{3, 8'h60, 1'b0, 4'b0111});
        tbl.push_back('{1, 8'h61, 1'b0, 4'b1101});
        for (int k = 0; k < 9; k++) begin
            tbl.push_back('{0, 8'(k), 1'b0, 4'b1110});
        end
        tbl.push_back('{0, 8'h00, 1'b0, 4'b1110});
        tbl.push_back('{1, 8'h08, 1'b1, 4'b0000});

        foreach (tbl[i]) begin
            if (!tbl[i].drop) begin
                q_bc.push_back('{data: tbl[i].data, mask: tbl[i].mask});
                if (tbl[i].side != 4) q_dlv.push_back(tbl[i].data);
                n_fwd++;
            end else begin
                n_drop++;
            end
            send(tbl[i].side, tbl[i].data);
            repeat (6) @(negedge clk);
            chk($sformatf("vec%0d_pending", i),
                32'({q_bc.size() == 0, q_dlv.size() == 0}), 32'h3);
        end

`ifdef EPIDEMIC_NODE_STATS_EN
        chk("stat_fwd", 32'(stat_fwd), 32'(n_fwd));
        chk("stat_drop", 32'(stat_drop), 32'(n_drop));
`endif

        ir = 4'b1101;
        q_bc.push_back('{data: 8'h12, mask: 4'b1110});
        q_dlv.push_back(8'h12);
        send(0, 8'h12);
        repeat (3) @(negedge clk);
        chk("bp_only_r", 32'(ov), 32'h2);
        chk("bp_data_r", 32'(od_r), 32'h12);
        q_bc.push_back('{data: 8'h13, mask: 4'b1011});
        q_dlv.push_back(8'h13);
        send(2, 8'h13);
        repeat (5) @(negedge clk);
        chk("bp_hold_r", 32'(ov), 32'h2);
        chk("bp_hold_data", 32'(od_r), 32'h12);
        ir = 4'hF;
        repeat (8) @(negedge clk);
        chk("bp_drain",
            32'({q_bc.size() == 0, q_dlv.size() == 0}), 32'h3);

        rstn = 1'b0;
        #1;
        chk("rst2_ov", 32'(ov), 32'h0);
        chk("rst2_ordy", 32'(ordy), 32'hF);
        @(negedge clk);
        rstn = 1'b1;

        @(negedge clk);
        q_bc.push_back('{data: 8'h10, mask: 4'b1110});
        q_bc.push_back('{data: 8'h20, mask: 4'b1101});
        q_bc.push_back('{data: 8'h30, mask: 4'b1011});
        q_bc.push_back('{data: 8'h40, mask: 4'b0111});
        q_dlv.push_back(8'h10);
        q_dlv.push_back(8'h20);
        q_dlv.push_back(8'h30);
        q_dlv.push_back(8'h40);
        in_d[0] = 8'h10;
        in_d[1] = 8'h20;
        in_d[2] = 8'h30;
        in_d[3] = 8'h40;
        in_v[3:0] = 4'hF;
        @(posedge clk);
        #1;
        in_v[3:0] = 4'h0;
        @(negedge clk);
        chk("rr_ordy_busy", 32'(ordy), 32'h0);
        @(negedge clk);
        chk("rr_ordy_l", 32'(ordy), 32'h1);
        repeat (2) @(negedge clk);
        chk("rr_ordy_lr", 32'(ordy), 32'h3);
        repeat (10) @(negedge clk);
        chk("rr_drain",
            32'({q_bc.size() == 0, q_dlv.size() == 0}), 32'h3);

        @(negedge clk);
        in_vc[0] = 1'b1;
        in_dc[0] = 8'h77;
        in_vc[4] = 1'b1;
        in_dc[4] = 8'hA1;
        @(posedge clk);
        #1;
        in_vc[4] = 1'b0;
        repeat (2) @(negedge clk);
        chk("c_ov", 32'(ov_c), 32'h6);
        chk("c_data", 32'({odc_r, odc_t}), 32'hA1A1);
        chk("c_ordy_edges", 32'(ordy_c & 4'b1001), 32'h0);
        repeat (3) @(negedge clk);
        chk("c_ov_hold", 32'(ov_c), 32'h6);
        chk("c_no_dlv", 32'(c_dlv_seen), 32'h0);
        #2;
        rstn_c = 1'b0;
        #1;
        chk("c_async_rst", 32'(ov_c), 32'h0);
        @(negedge clk);
        rstn_c = 1'b1;
        irc = 4'hF;
        repeat (5) @(negedge clk);
        chk("c_ignored_l", 32'(ov_c), 32'h0);
        chk("c_ordy_after", 32'(ordy_c), 32'h6);
        chk("c_no_dlv_end", 32'(c_dlv_seen), 32'h0);
        in_vc[0] = 1'b0;

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
